// File: rtl/parking_gate_ctrl.sv
// Entry-lane access controller: arrival/passage sensors, PIN keypad, wrong-attempt
// and block alarms, gate-open timeout and lot occupancy tracking.
module parking_gate_ctrl #(
  parameter int                PIN_W     = 8,
  parameter logic [PIN_W-1:0]  PIN       = 8'd87,
  parameter int                MAX_TRIES = 3,
  parameter int                CAP       = 16,
  parameter int                OPEN_TO   = 64,
  localparam int               OCC_W     = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_1,
  input  logic             sensor_2,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             car_exit,
  output logic             alarm_1,
  output logic             alarm_2,
  output logic             open_gate,
  output logic             close_gate,
  output logic             full,
  output logic [OCC_W-1:0] occupancy,
  output logic [1:0]       dbg_state
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W  = $clog2(OPEN_TO + 1);

  localparam logic [TRY_W-1:0] MAX_T   = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE = TRY_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(OPEN_TO - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [OCC_W-1:0] CAP_V   = OCC_W'(CAP);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // Encoding is visible on dbg_state: 0 idle, 1 PIN entry, 2 gate open, 3 blocked.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PIN_ENTRY = 2'd1,
    S_GATE_OPEN = 2'd2,
    S_BLOCKED   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [TRY_W-1:0] tries, tries_n, tries_inc;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [OCC_W-1:0] occupancy_n;
  logic             alarm_1_n, alarm_2_n, open_gate_n, close_gate_n, full_n;
  logic             good_pin, bad_pin, blk;
  logic             passage, inc_ok, dec_ok;

  assign good_pin  = pin_valid && (pin == PIN);
  assign bad_pin   = pin_valid && (pin != PIN);
  assign blk       = sensor_1 && sensor_2;
  assign tries_inc = (tries == MAX_T) ? tries : tries + TRY_ONE;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tries      <= '0;
      to_cnt     <= '0;
      occupancy  <= '0;
      alarm_1    <= 1'b0;
      alarm_2    <= 1'b0;
      open_gate  <= 1'b0;
      close_gate <= 1'b0;
      full       <= 1'b0;
    end else begin
      state      <= state_n;
      tries      <= tries_n;
      to_cnt     <= to_cnt_n;
      occupancy  <= occupancy_n;
      alarm_1    <= alarm_1_n;
      alarm_2    <= alarm_2_n;
      open_gate  <= open_gate_n;
      close_gate <= close_gate_n;
      full       <= full_n;
    end
  end

  always_comb begin
    state_n      = state;
    tries_n      = tries;
    to_cnt_n     = to_cnt;
    alarm_1_n    = alarm_1;
    alarm_2_n    = alarm_2;
    open_gate_n  = open_gate;
    close_gate_n = 1'b0;
    passage      = 1'b0;

    case (state)
      S_IDLE: begin
        if (blk) begin
          state_n     = S_BLOCKED;
          alarm_2_n   = 1'b1;
          open_gate_n = 1'b0;
        end else if (sensor_1 && !full) begin
          state_n = S_PIN_ENTRY;
        end
      end
      S_PIN_ENTRY: begin
        if (blk) begin
          state_n     = S_BLOCKED;
          alarm_2_n   = 1'b1;
          open_gate_n = 1'b0;
        end else if (good_pin) begin
          state_n     = S_GATE_OPEN;
          open_gate_n = 1'b1;
          tries_n     = '0;
          alarm_1_n   = 1'b0;
          to_cnt_n    = '0;
        end else if (bad_pin) begin
          tries_n = tries_inc;
          if (tries_inc == MAX_T) alarm_1_n = 1'b1;
        end else if (!sensor_1) begin
          // Walking away keeps the attempt count so retries cannot reset it.
          state_n = S_IDLE;
        end
      end
      S_GATE_OPEN: begin
        if (blk) begin
          state_n      = S_BLOCKED;
          alarm_2_n    = 1'b1;
          open_gate_n  = 1'b0;
          close_gate_n = 1'b1;
        end else if (sensor_2) begin
          state_n      = S_IDLE;
          open_gate_n  = 1'b0;
          close_gate_n = 1'b1;
          passage      = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_n      = S_IDLE;
          open_gate_n  = 1'b0;
          close_gate_n = 1'b1;
        end else begin
          to_cnt_n = to_cnt + TO_ONE;
        end
      end
      S_BLOCKED: begin
        if (good_pin) begin
          state_n   = S_IDLE;
          alarm_2_n = 1'b0;
          alarm_1_n = 1'b0;
          tries_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Entry and exit in the same cycle cancel; each side is bounded on its own.
    inc_ok      = passage && (occupancy != CAP_V);
    dec_ok      = car_exit && (occupancy != '0);
    occupancy_n = occupancy;
    if (inc_ok && !dec_ok)      occupancy_n = occupancy + OCC_ONE;
    else if (dec_ok && !inc_ok) occupancy_n = occupancy - OCC_ONE;
    full_n = (occupancy_n == CAP_V);
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the lane.
module tb_parking_gate_ctrl;

  localparam int PIN_W     = 8;
  localparam int PIN_V     = 87;
  localparam int MAX_TRIES = 3;
  localparam int CAP       = 2;
  localparam int OPEN_TO   = 64;
  localparam int OCC_W     = $clog2(CAP + 1);
  localparam int W         = OCC_W + 7;

  localparam int M_IDLE = 0, M_PIN = 1, M_OPEN = 2, M_BLK = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sensor_1, sensor_2, pin_valid, car_exit;
  logic [PIN_W-1:0] pin;
  logic             alarm_1, alarm_2, open_gate, close_gate, full;
  logic [OCC_W-1:0] occupancy;
  logic [1:0]       dbg_state;

  parking_gate_ctrl #(
    .PIN_W(PIN_W), .PIN(8'd87), .MAX_TRIES(MAX_TRIES), .CAP(CAP), .OPEN_TO(OPEN_TO)
  ) dut (
    .clk(clk), .rst(rst), .sensor_1(sensor_1), .sensor_2(sensor_2),
    .pin_valid(pin_valid), .pin(pin), .car_exit(car_exit),
    .alarm_1(alarm_1), .alarm_2(alarm_2), .open_gate(open_gate),
    .close_gate(close_gate), .full(full), .occupancy(occupancy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: lane phase, wrong-attempt count, open cycles remaining, car count.
  int m_mode, m_wrong, m_left, m_occ;
  bit m_a1, m_a2, m_open, m_close;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [1:0] md;
    logic [OCC_W-1:0] oc;
    md = 2'(m_mode);
    oc = OCC_W'(m_occ);
    return {md, m_a1, m_a2, m_open, m_close, (m_occ == CAP), oc};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_wrong = 0; m_left = 0; m_occ = 0;
    m_a1 = 0; m_a2 = 0; m_open = 0; m_close = 0;
    exp_q.push_back(pack_model());
  endtask

  task automatic model_step(input bit s1, input bit s2, input bit pv, input int p, input bit ce);
    bit good, bad, blk, passed;
    int delta;
    good = pv && (p == PIN_V);
    bad = pv && (p != PIN_V);
    blk = s1 && s2;
    passed = 0;
    m_close = 0;
    if (blk && m_mode != M_BLK) begin
      if (m_mode == M_OPEN) m_close = 1;
      m_mode = M_BLK; m_a2 = 1; m_open = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s1 && m_occ < CAP) m_mode = M_PIN;
        M_PIN: begin
          if (good) begin
            m_mode = M_OPEN; m_open = 1; m_wrong = 0; m_a1 = 0; m_left = OPEN_TO;
          end else if (bad) begin
            if (m_wrong < MAX_TRIES) m_wrong++;
            if (m_wrong == MAX_TRIES) m_a1 = 1;
          end else if (!s1) m_mode = M_IDLE;
        end
        M_OPEN: begin
          if (s2) begin
            m_mode = M_IDLE; m_open = 0; m_close = 1; passed = 1;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_mode = M_IDLE; m_open = 0; m_close = 1;
            end
          end
        end
        default: if (good) begin
          m_mode = M_IDLE; m_a2 = 0; m_a1 = 0; m_wrong = 0;
        end
      endcase
    end
    delta = ((passed && m_occ < CAP) ? 1 : 0) - ((ce && m_occ > 0) ? 1 : 0);
    m_occ = m_occ + delta;
    exp_q.push_back(pack_model());
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("state",      32'(dbg_state),  32'(e[W-1:W-2]));
    check("alarm_1",    32'(alarm_1),    32'(e[OCC_W+4]));
    check("alarm_2",    32'(alarm_2),    32'(e[OCC_W+3]));
    check("open_gate",  32'(open_gate),  32'(e[OCC_W+2]));
    check("close_gate", 32'(close_gate), 32'(e[OCC_W+1]));
    check("full",       32'(full),       32'(e[OCC_W]));
    check("occupancy",  32'(occupancy),  32'(e[OCC_W-1:0]));
  endtask

  task automatic cycle(input bit s1, input bit s2, input bit pv, input int p, input bit ce);
    rst = 1'b0; sensor_1 = s1; sensor_2 = s2; pin_valid = pv; pin = PIN_W'(p); car_exit = ce;
    model_step(s1, s2, pv, p, ce);
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic do_reset(input bit s1, input bit s2, input bit pv, input int p, input bit ce);
    rst = 1'b1; sensor_1 = s1; sensor_2 = s2; pin_valid = pv; pin = PIN_W'(p); car_exit = ce;
    model_reset();
    @(posedge clk); #1;
    compare_outputs();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int open_cycles;
    bit s1, s2, pv, ce;
    int p;

    rst = 1'b1; sensor_1 = 0; sensor_2 = 0; pin_valid = 0; pin = '0; car_exit = 0;
    @(posedge clk); #1;
    do_reset(1, 1, 1, PIN_V, 1);
    check("reset_occ", 32'(occupancy), 32'd0);

    // Admit one car.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    check("open_after_good_pin", 32'(open_gate), 32'd1);
    cycle(0, 1, 0, 0, 0);
    check("close_pulse_on_pass", 32'(close_gate), 32'd1);
    check("occ_after_pass", 32'(occupancy), 32'd1);
    idle(1);
    check("close_pulse_ends", 32'(close_gate), 32'd0);

    // Three wrong PINs raise alarm_1; leaving keeps it; good PIN clears it.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 5, 0);
    cycle(1, 0, 1, 6, 0);
    check("no_alarm_after_two", 32'(alarm_1), 32'd0);
    cycle(1, 0, 1, 7, 0);
    check("alarm_after_three", 32'(alarm_1), 32'd1);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    check("alarm_cleared", 32'(alarm_1), 32'd0);
    cycle(0, 1, 0, 0, 0);
    check("lot_full", 32'(full), 32'd1);

    // Full lot ignores arrivals; an exit frees a space.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("full_stays_idle", 32'(dbg_state), 32'(M_IDLE));
    cycle(0, 0, 0, 0, 1);
    check("exit_clears_full", 32'(full), 32'd0);

    // Block while gate is open, wrong PIN ignored, good PIN releases.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    cycle(1, 1, 0, 0, 0);
    check("block_alarm", 32'(alarm_2), 32'd1);
    cycle(1, 1, 1, 3, 0);
    check("blocked_holds", 32'(dbg_state), 32'(M_BLK));
    cycle(0, 0, 1, PIN_V, 0);
    check("block_released", 32'(alarm_2), 32'd0);

    // Timeout with no passage.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, PIN_V, 0);
    open_cycles = 1;
    for (int i = 0; i < OPEN_TO + 8; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (open_gate) open_cycles++;
    end
    check("timeout_open_cycles", 32'(open_cycles), 32'(OPEN_TO));

    // Drain to zero, then exit at zero is ignored.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("exit_at_zero", 32'(occupancy), 32'd0);

    // Passage and exit together leave occupancy alone.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    cycle(0, 1, 0, 0, 1);
    check("pass_and_exit", 32'(occupancy), 32'd1);

    // Reset while the gate is open.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, PIN_V, 0);
    do_reset(1, 0, 0, 0, 0);
    check("reset_closes_gate", 32'(open_gate), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s1 = ($urandom_range(0, 99) < 55);
      s2 = ($urandom_range(0, 99) < 20);
      pv = ($urandom_range(0, 99) < 25);
      p  = ($urandom_range(0, 1) == 1) ? PIN_V : int'($urandom_range(0, 255));
      ce = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 299) == 0) do_reset(s1, s2, pv, p, ce);
      else cycle(s1, s2, pv, p, ce);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Parametrised parking-entrance access controller. It gates a single entry lane using an arrival sensor, a passage sensor and a strobed PIN keypad. Compared with the first-generation controller it adds configurable PIN width and value, a configurable wrong-attempt limit, a gate-open timeout, and a lot-occupancy counter with a full flag and an exit-lane decrement input. It sits between the lane sensors/keypad front end and the barrier actuator driver.

## Interface
- `PIN_W`, 8: PIN width in bits.
- `PIN`, 8'd87: correct PIN value, `PIN_W` bits.
- `MAX_TRIES`, 3: number of consecutive wrong PINs that raises `alarm_1`. Must be ≥1.
- `CAP`, 16: lot capacity. Must be ≥1.
- `OPEN_TO`, 64: clock cycles the gate stays open without passage before it auto-closes. Must be ≥1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sensor_1`, input, 1: car present at the entry gate.
- `sensor_2`, input, 1: car has passed the gate.
- `pin_valid`, input, 1: one-cycle strobe; `pin` is sampled in that cycle.
- `pin`, input, `PIN_W`: PIN attempt.
- `car_exit`, input, 1: one-cycle pulse from the exit lane; decrements occupancy.
- `alarm_1`, output, 1: wrong-PIN alarm.
- `alarm_2`, output, 1: block alarm (both sensors active at once).
- `open_gate`, output, 1: high while the gate is commanded open.
- `close_gate`, output, 1: one-cycle close-command pulse.
- `full`, output, 1: high when `occupancy == CAP`.
- `occupancy`, output, `$clog2(CAP+1)`: current car count.

## Operation
- Four states: IDLE, PIN_ENTRY, GATE_OPEN, BLOCKED.
- All outputs are registered and update on the same edge as the state register.
- Internal counters:
  - `tries`: `$clog2(MAX_TRIES+1)` bits, saturates at `MAX_TRIES`.
  - `to_cnt`: `$clog2(OPEN_TO+1)` bits.
- A "good PIN" is `pin_valid && pin == PIN`. A "bad PIN" is `pin_valid && pin != PIN`.
- Block condition (`sensor_1 && sensor_2`) is evaluated in IDLE, PIN_ENTRY and GATE_OPEN. It has the highest priority in each:
  - next state is BLOCKED;
  - `alarm_2` is set to 1;
  - `open_gate` is set to 0;
  - if leaving GATE_OPEN, `close_gate` pulses.
- IDLE:
  - `sensor_1 && !full` → PIN_ENTRY.
  - `sensor_1 && full` → stay in IDLE; the arrival is ignored.
- PIN_ENTRY:
  - Good PIN → GATE_OPEN. Set `open_gate=1`, clear `tries` and `alarm_1`, load `to_cnt=0`.
  - Bad PIN → stay. Increment `tries` (saturating). When the incremented value equals `MAX_TRIES`, set `alarm_1=1` in the same update.
  - `!sensor_1` with no `pin_valid` → IDLE. `tries` and `alarm_1` are retained, so leaving does not reset the attempt count.
  - `pin_valid` outside PIN_ENTRY and BLOCKED is ignored.
- GATE_OPEN:
  - `sensor_2` → IDLE. Set `open_gate=0`, pulse `close_gate`, increment occupancy.
  - Otherwise `to_cnt` increments each cycle. When `to_cnt == OPEN_TO-1` → IDLE, with `open_gate=0`, `close_gate` pulse and no occupancy change.
- BLOCKED:
  - Only a good PIN exits, to IDLE. It clears `alarm_2`, `alarm_1` and `tries`.
  - Bad PINs are not counted. Sensors are ignored.
- Occupancy:
  - Increment (passage) and `car_exit` decrement are applied in the same cycle. When both occur, occupancy is unchanged.
  - `car_exit` at occupancy 0 is ignored. The count never exceeds `CAP`.
  - `full` is registered from the next occupancy value.
- `close_gate` is high for exactly one cycle per gate closure and is 0 otherwise.

## Timing
- Reset values: state IDLE; `tries=0`, `to_cnt=0`, `occupancy=0`; `alarm_1=0`, `alarm_2=0`, `open_gate=0`, `close_gate=0`, `full=0`. Reset has priority over every input.
- Reset in any state, including GATE_OPEN, forces the gate closed (`open_gate=0`) with no `close_gate` pulse. Occupancy is cleared.
- Latency:
  - Input sampled at edge N → state and outputs valid after edge N.
  - Good PIN at cycle t → `open_gate=1` from cycle t+1.
  - `sensor_2` at cycle t → `open_gate=0` and `close_gate=1` at cycle t+1, `close_gate=0` at t+2.
- Timeout: with no passage, `open_gate` is high for exactly `OPEN_TO` cycles.
- Sensors are level inputs. The block performs no debouncing.

## Test plan
- Reset, then `sensor_1=1`, then `pin_valid` with `pin=87` → `open_gate=1` the next cycle. Then `sensor_2=1` → `close_gate` one-cycle pulse, `occupancy=1`, state IDLE.
- Three bad PINs (e.g. 5, 6, 7) in PIN_ENTRY → `alarm_1=1` in the cycle after the third. Drop `sensor_1`, re-arrive, then good PIN → `alarm_1=0`, gate opens.
- `sensor_1=sensor_2=1` in GATE_OPEN → `alarm_2=1`, `open_gate=0`, `close_gate` pulse. Bad PIN 3 → stays BLOCKED. PIN 87 → IDLE, `alarm_2=0`.
- With `OPEN_TO=64`: good PIN, then no `sensor_2` → `open_gate` high for exactly 64 cycles, `close_gate` pulse, `occupancy` unchanged.
- With `CAP=2`: admit two cars → `full=1`. A further `sensor_1` stays IDLE. `car_exit` → `occupancy=1`, `full=0`. `car_exit` at 0 → stays 0.
- Passage `sensor_2` and `car_exit` in the same cycle → `occupancy` unchanged. Assert `rst` during GATE_OPEN → all outputs 0 the next cycle.
